// File: rtl/screen_sequencer_pkg.sv
// Shared types and constants for the Memory Game screen sequencer.
// Holds card-count constants, the screen state encoding and enable helper.
package screen_sequencer_pkg;

  localparam int CARD_MAX_NUM_SIZE = 5;

  localparam logic [CARD_MAX_NUM_SIZE-1:0] CARD_NUM_EASY   = 5'd8;
  localparam logic [CARD_MAX_NUM_SIZE-1:0] CARD_NUM_NORMAL = 5'd16;
  localparam logic [CARD_MAX_NUM_SIZE-1:0] CARD_NUM_HARD   = 5'd24;

  // 2 s at 65 MHz
  localparam int RESULT_HOLD_DEFAULT   = 130_000_000;
  localparam int HOLD_CNT_SIZE_DEFAULT = 28;

  // Also consumed by the VGA overlay mux
  typedef enum logic [1:0] {
    SCR_MENU    = 2'd0,
    SCR_OPTIONS = 2'd1,
    SCR_GAME    = 2'd2,
    SCR_RESULT  = 2'd3
  } screen_t;

  typedef struct packed {
    logic menu;
    logic options;
    logic game;
    logic result;
  } screen_en_t;

  function automatic screen_en_t screen_enables(screen_t s);
    screen_en_t en;
    en = '0;
    unique case (s)
      SCR_OPTIONS: en.options = 1'b1;
      SCR_GAME:    en.game    = 1'b1;
      SCR_RESULT:  en.result  = 1'b1;
      default:     en.menu    = 1'b1;
    endcase
    return en;
  endfunction

endpackage

// File: rtl/screen_sequencer_if.sv
// Bundle between the screen blocks and the screen sequencer.
// master = screen blocks / mouse side, slave = screen_sequencer.
interface screen_sequencer_if;
  import screen_sequencer_pkg::*;

  logic                         mouse_left;
  logic                         start_butt_pressed;
  logic                         options_butt_pressed;
  logic                         difficulty_butts_pressed;
  logic [CARD_MAX_NUM_SIZE-1:0] num_of_cards_sel;
  logic                         game_over;
  logic                         game_won;

  logic                         menu_enable;
  logic                         options_enable;
  logic                         game_enable;
  logic                         result_enable;
  logic                         game_start;
  logic [CARD_MAX_NUM_SIZE-1:0] game_num_of_cards;
  logic                         result_won;
  logic                         clicks_armed;
  screen_t                      screen_state;

  modport master (
    output mouse_left,
    output start_butt_pressed,
    output options_butt_pressed,
    output difficulty_butts_pressed,
    output num_of_cards_sel,
    output game_over,
    output game_won,
    input  menu_enable,
    input  options_enable,
    input  game_enable,
    input  result_enable,
    input  game_start,
    input  game_num_of_cards,
    input  result_won,
    input  clicks_armed,
    input  screen_state
  );

  modport slave (
    input  mouse_left,
    input  start_butt_pressed,
    input  options_butt_pressed,
    input  difficulty_butts_pressed,
    input  num_of_cards_sel,
    input  game_over,
    input  game_won,
    output menu_enable,
    output options_enable,
    output game_enable,
    output result_enable,
    output game_start,
    output game_num_of_cards,
    output result_won,
    output clicks_armed,
    output screen_state
  );

endinterface

// File: rtl/screen_sequencer_click_guard.sv
// Click-through guard: armed only after the mouse is seen released.
// Ports: clk, rst, mouse_left_i, trans_i (transition strobe), armed_o.
module click_guard (
  input  logic clk,
  input  logic rst,
  input  logic mouse_left_i,
  input  logic trans_i,
  output logic armed_o
);

  logic armed_q;
  logic armed_d;

  // A transition always disarms, even if the button is up that cycle,
  // so the new screen needs one clean released cycle of its own.
  always_comb begin
    armed_d = armed_q;
    if (trans_i)
      armed_d = 1'b0;
    else if (!armed_q && !mouse_left_i)
      armed_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) armed_q <= 1'b0;
    else     armed_q <= armed_d;
  end

  assign armed_o = armed_q;

endmodule

// File: rtl/screen_sequencer.sv
// Top-level screen FSM: MENU -> OPTIONS/GAME -> RESULT -> MENU.
// Ports: clk, rst (sync, active high), bus (screen_sequencer_if.slave).
module screen_sequencer
  import screen_sequencer_pkg::*;
#(
  parameter int RESULT_HOLD_CYCLES = RESULT_HOLD_DEFAULT,
  parameter int HOLD_CNT_SIZE      = HOLD_CNT_SIZE_DEFAULT
) (
  input logic               clk,
  input logic               rst,
  screen_sequencer_if.slave bus
);

  localparam logic [HOLD_CNT_SIZE-1:0] HOLD_LOAD =
    HOLD_CNT_SIZE'(RESULT_HOLD_CYCLES);
  localparam logic [HOLD_CNT_SIZE-1:0] HOLD_ONE =
    HOLD_CNT_SIZE'(1);

  screen_t                      state_q;
  screen_t                      state_d;
  screen_en_t                   en_q;
  logic                         game_start_q;
  logic [CARD_MAX_NUM_SIZE-1:0] cards_q;
  logic                         won_q;
  logic [HOLD_CNT_SIZE-1:0]     hold_q;
  logic                         armed;
  logic                         trans;

  click_guard u_guard (
    .clk          (clk),
    .rst          (rst),
    .mouse_left_i (bus.mouse_left),
    .trans_i      (trans),
    .armed_o      (armed)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      SCR_MENU: begin
        if (armed && bus.start_butt_pressed)
          state_d = SCR_GAME;
        else if (armed && bus.options_butt_pressed)
          state_d = SCR_OPTIONS;
      end
      SCR_OPTIONS: begin
        if (armed && bus.difficulty_butts_pressed)
          state_d = SCR_MENU;
      end
      SCR_GAME: begin
        // end of game is not a user click, so no arming needed
        if (bus.game_over)
          state_d = SCR_RESULT;
      end
      SCR_RESULT: begin
        if (hold_q == '0 && armed && bus.mouse_left)
          state_d = SCR_MENU;
      end
      default: state_d = SCR_MENU;
    endcase
  end

  assign trans = (state_d != state_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= SCR_MENU;
      en_q         <= screen_enables(SCR_MENU);
      game_start_q <= 1'b0;
      cards_q      <= CARD_NUM_NORMAL;
      won_q        <= 1'b0;
      hold_q       <= '0;
    end else begin
      state_q      <= state_d;
      en_q         <= screen_enables(state_d);
      game_start_q <= 1'b0;
      unique case (state_q)
        SCR_MENU: begin
          if (state_d == SCR_GAME) begin
            game_start_q <= 1'b1;
            cards_q      <= bus.num_of_cards_sel;
          end
        end
        SCR_OPTIONS: ;
        SCR_GAME: begin
          if (state_d == SCR_RESULT) begin
            won_q  <= bus.game_won;
            hold_q <= HOLD_LOAD;
          end
        end
        SCR_RESULT: begin
          if (hold_q != '0)
            hold_q <= hold_q - HOLD_ONE;
        end
        default: begin
          en_q         <= screen_enables(SCR_MENU);
          cards_q      <= CARD_NUM_NORMAL;
          won_q        <= 1'b0;
          hold_q       <= '0;
        end
      endcase
    end
  end

  assign bus.menu_enable       = en_q.menu;
  assign bus.options_enable    = en_q.options;
  assign bus.game_enable       = en_q.game;
  assign bus.result_enable     = en_q.result;
  assign bus.game_start        = game_start_q;
  assign bus.game_num_of_cards = cards_q;
  assign bus.result_won        = won_q;
  assign bus.clicks_armed      = armed;
  assign bus.screen_state      = state_q;

endmodule

// File: tb/tb_screen_sequencer.sv
// Directed self-checking bench for screen_sequencer.
// Uses a short result hold so expiry boundaries are reachable.
module tb_screen_sequencer;
  import screen_sequencer_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;
  bit   mon_on = 1'b0;

  always #5 clk = ~clk;

  screen_sequencer_if bus ();

  screen_sequencer #(
    .RESULT_HOLD_CYCLES (8),
    .HOLD_CNT_SIZE      (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // one-hot enables on every cycle once out of reset
  always @(negedge clk) begin
    if (mon_on)
      chk("onehot",
          32'(bus.menu_enable) + 32'(bus.options_enable) +
          32'(bus.game_enable) + 32'(bus.result_enable), 1);
  end

  initial begin
    bus.mouse_left               = 1'b1;
    bus.start_butt_pressed       = 1'b0;
    bus.options_butt_pressed     = 1'b0;
    bus.difficulty_butts_pressed = 1'b0;
    bus.num_of_cards_sel         = CARD_NUM_NORMAL;
    bus.game_over                = 1'b0;
    bus.game_won                 = 1'b0;
    step(2);
    rst = 1'b0;
    mon_on = 1'b1;

    chk("rst_menu", bus.menu_enable, 1);
    chk("rst_opt", bus.options_enable, 0);
    chk("rst_game", bus.game_enable, 0);
    chk("rst_res", bus.result_enable, 0);
    chk("rst_start", bus.game_start, 0);
    chk("rst_won", bus.result_won, 0);
    chk("rst_cards", bus.game_num_of_cards, CARD_NUM_NORMAL);
    chk("rst_armed", bus.clicks_armed, 0);

    // start while mouse held since reset: ignored
    bus.start_butt_pressed = 1'b1; step();
    bus.start_butt_pressed = 1'b0;
    chk("held_menu", bus.menu_enable, 1);
    chk("held_armed", bus.clicks_armed, 0);
    bus.mouse_left = 1'b0; step();
    chk("arm_set", bus.clicks_armed, 1);
    chk("no_memory", bus.menu_enable, 1);
    bus.start_butt_pressed = 1'b1; step();
    bus.start_butt_pressed = 1'b0;
    chk("g1_enable", bus.game_enable, 1);
    chk("g1_start", bus.game_start, 1);
    chk("g1_cards", bus.game_num_of_cards, CARD_NUM_NORMAL);
    chk("g1_disarm", bus.clicks_armed, 0);
    step();
    chk("g1_start_end", bus.game_start, 0);
    chk("g1_stay", bus.game_enable, 1);

    // win, mouse held from game_over through expiry
    bus.mouse_left = 1'b1;
    bus.game_over = 1'b1; bus.game_won = 1'b1; step();
    bus.game_over = 1'b0; bus.game_won = 1'b0;
    chk("r1_enable", bus.result_enable, 1);
    chk("r1_won", bus.result_won, 1);
    step(12);
    chk("r1_held_stay", bus.result_enable, 1);
    chk("r1_held_armed", bus.clicks_armed, 0);
    bus.mouse_left = 1'b0; step();
    chk("r1_rel_armed", bus.clicks_armed, 1);
    chk("r1_rel_stay", bus.result_enable, 1);
    bus.mouse_left = 1'b1; step();
    chk("r1_exit", bus.menu_enable, 1);
    chk("r1_exit_armed", bus.clicks_armed, 0);

    // options, then pick HARD
    bus.mouse_left = 1'b0; step();
    bus.options_butt_pressed = 1'b1; step();
    bus.options_butt_pressed = 1'b0;
    chk("opt_enable", bus.options_enable, 1);
    chk("opt_disarm", bus.clicks_armed, 0);
    step();
    bus.num_of_cards_sel = CARD_NUM_HARD;
    bus.difficulty_butts_pressed = 1'b1; step();
    bus.difficulty_butts_pressed = 1'b0;
    chk("opt_back", bus.menu_enable, 1);
    chk("opt_nolatch", bus.game_num_of_cards, CARD_NUM_NORMAL);
    step();
    bus.start_butt_pressed = 1'b1; step();
    bus.start_butt_pressed = 1'b0;
    chk("g2_enable", bus.game_enable, 1);
    chk("g2_cards", bus.game_num_of_cards, CARD_NUM_HARD);
    bus.num_of_cards_sel = CARD_NUM_EASY; step(2);
    chk("g2_frozen", bus.game_num_of_cards, CARD_NUM_HARD);
    bus.options_butt_pressed = 1'b1; step();
    bus.options_butt_pressed = 1'b0;
    chk("g2_ign_opt", bus.game_enable, 1);

    // loss; early click and boundary at counter == 1
    bus.game_over = 1'b1; bus.game_won = 1'b0; step();
    bus.game_over = 1'b0;
    chk("r2_enable", bus.result_enable, 1);
    chk("r2_won", bus.result_won, 0);
    step(3);
    chk("r2_armed", bus.clicks_armed, 1);
    bus.mouse_left = 1'b1; step();
    bus.mouse_left = 1'b0;
    chk("r2_click5", bus.result_enable, 1);
    bus.game_over = 1'b1; bus.game_won = 1'b1; step();
    bus.game_over = 1'b0; bus.game_won = 1'b0;
    chk("r2_ign_over", bus.result_won, 0);
    chk("r2_ign_stay", bus.result_enable, 1);
    step(2);
    bus.mouse_left = 1'b1; step();
    chk("r2_cnt1", bus.result_enable, 1);
    step();
    chk("r2_exit", bus.menu_enable, 1);

    // start and options together: start wins
    bus.mouse_left = 1'b0; step();
    bus.start_butt_pressed = 1'b1;
    bus.options_butt_pressed = 1'b1; step();
    bus.start_butt_pressed = 1'b0;
    bus.options_butt_pressed = 1'b0;
    chk("both_game", bus.game_enable, 1);
    chk("both_opt", bus.options_enable, 0);
    chk("both_cards", bus.game_num_of_cards, CARD_NUM_EASY);
    step();
    chk("both_opt2", bus.options_enable, 0);

    // reset mid-game with mouse held
    bus.mouse_left = 1'b1;
    rst = 1'b1; step();
    rst = 1'b0;
    chk("mrst_menu", bus.menu_enable, 1);
    chk("mrst_game", bus.game_enable, 0);
    chk("mrst_cards", bus.game_num_of_cards, CARD_NUM_NORMAL);
    chk("mrst_start", bus.game_start, 0);
    chk("mrst_armed", bus.clicks_armed, 0);
    step();
    chk("mrst_start2", bus.game_start, 0);
    chk("mrst_stay", bus.menu_enable, 1);

    mon_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
